// File: rtl/dcache_line_refill_ctrl.sv
// Miss-handling sequencer for the two-way L1 D-cache data RAM.
// On an accepted miss it optionally writes the dirty victim line back to
// memory (read RAM word, capture, send beat), then fetches the new line and
// writes each returned beat straight into the selected way. A one-cycle done
// pulse tells the D-cache main FSM that the line is in place.
module dcache_line_refill_ctrl #(
    parameter int OFFSET_W = 3,
    parameter int INDEX_W  = 12 - OFFSET_W
) (
    input  logic               clk,
    input  logic               rst,
    // miss request from the D-cache main FSM
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_way,
    input  logic [INDEX_W-1:0] req_index,
    input  logic               req_wb,
    input  logic [31:0]        req_wb_addr,
    input  logic [31:0]        req_rf_addr,
    output logic               busy,
    output logic               done,
    output logic               err,
    // data RAM port
    output logic [11:0]        ram_addr,
    output logic [1:0]         ram_en,
    output logic [7:0]         ram_wen,
    output logic [31:0]        ram_data0_w,
    output logic [31:0]        ram_data1_w,
    input  logic [31:0]        ram_data0_o,
    input  logic [31:0]        ram_data1_o,
    // refill read burst
    output logic               rd_req,
    output logic [31:0]        rd_addr,
    input  logic               rd_gnt,
    input  logic               rd_valid,
    input  logic [31:0]        rd_data,
    input  logic               rd_last,
    // writeback burst
    output logic               wr_req,
    output logic [31:0]        wr_addr,
    input  logic               wr_gnt,
    output logic               wr_valid,
    output logic [31:0]        wr_data,
    output logic               wr_last,
    input  logic               wr_ready,
    input  logic               wr_resp
);

    localparam int LINE_WORDS = 2 ** OFFSET_W;
    localparam logic [OFFSET_W-1:0] CNT_LAST = OFFSET_W'(LINE_WORDS - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        WB_REQ = 4'd1,
        WB_RD  = 4'd2,
        WB_CAP = 4'd3,
        WB_DAT = 4'd4,
        WB_RSP = 4'd5,
        RF_REQ = 4'd6,
        RF_DAT = 4'd7,
        DONE   = 4'd8
    } state_t;

    state_t              state_reg, state_next;
    logic [OFFSET_W-1:0] cnt_reg, cnt_next;
    logic [31:0]         wb_buf_reg, wb_buf_next;
    logic                way_reg, way_next;
    logic [INDEX_W-1:0]  index_reg, index_next;
    logic                wb_reg, wb_next;
    logic [31:0]         wb_addr_reg, wb_addr_next;
    logic [31:0]         rf_addr_reg, rf_addr_next;
    logic                err_reg, err_next;

    // RAM access qualifiers; the way decode below turns them into per-way strobes
    logic                ram_access;
    logic                ram_write;
    logic [31:0]         ram_wdata;

    // State and latched request fields; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            wb_buf_reg  <= '0;
            way_reg     <= 1'b0;
            index_reg   <= '0;
            wb_reg      <= 1'b0;
            wb_addr_reg <= '0;
            rf_addr_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            wb_buf_reg  <= wb_buf_next;
            way_reg     <= way_next;
            index_reg   <= index_next;
            wb_reg      <= wb_next;
            wb_addr_reg <= wb_addr_next;
            rf_addr_reg <= rf_addr_next;
            err_reg     <= err_next;
        end
    end

    // Next-state logic and state-decoded outputs; only the refill RAM write
    // path looks at the live rd_valid/rd_data inputs
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        wb_buf_next  = wb_buf_reg;
        way_next     = way_reg;
        index_next   = index_reg;
        wb_next      = wb_reg;
        wb_addr_next = wb_addr_reg;
        rf_addr_next = rf_addr_reg;
        err_next     = err_reg;

        req_ready  = 1'b0;
        busy       = (state_reg != IDLE);
        done       = 1'b0;
        err        = err_reg;
        ram_addr   = '0;
        ram_access = 1'b0;
        ram_write  = 1'b0;
        ram_wdata  = '0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        wr_req     = 1'b0;
        wr_addr    = '0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        wr_last    = 1'b0;

        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    way_next     = req_way;
                    index_next   = req_index;
                    wb_next      = req_wb;
                    wb_addr_next = req_wb_addr;
                    rf_addr_next = req_rf_addr;
                    cnt_next     = '0;
                    err_next     = 1'b0;
                    state_next   = req_wb ? WB_REQ : RF_REQ;
                end
            end
            WB_REQ: begin
                wr_req  = 1'b1;
                wr_addr = wb_addr_reg;
                if (wr_gnt) begin
                    state_next = WB_RD;
                end
            end
            WB_RD: begin
                // read-only access; data appears on the next cycle
                ram_access = 1'b1;
                ram_addr   = {index_reg, cnt_reg};
                state_next = WB_CAP;
            end
            WB_CAP: begin
                wb_buf_next = way_reg ? ram_data1_o : ram_data0_o;
                state_next  = WB_DAT;
            end
            WB_DAT: begin
                wr_valid = 1'b1;
                wr_data  = wb_buf_reg;
                wr_last  = (cnt_reg == CNT_LAST);
                if (wr_ready) begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = WB_RSP;
                    end else begin
                        cnt_next   = cnt_reg + OFFSET_W'(1);
                        state_next = WB_RD;
                    end
                end
            end
            WB_RSP: begin
                if (wr_resp) begin
                    state_next = RF_REQ;
                end
            end
            RF_REQ: begin
                rd_req  = 1'b1;
                rd_addr = rf_addr_reg;
                if (rd_gnt) begin
                    state_next = RF_DAT;
                end
            end
            RF_DAT: begin
                if (rd_valid) begin
                    ram_access = 1'b1;
                    ram_write  = 1'b1;
                    ram_addr   = {index_reg, cnt_reg};
                    ram_wdata  = rd_data;
                    cnt_next   = cnt_reg + OFFSET_W'(1);
                    // the beat count decides completion; rd_last only flags disagreement
                    if (rd_last != (cnt_reg == CNT_LAST)) begin
                        err_next = 1'b1;
                    end
                    if (cnt_reg == CNT_LAST) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Both way write ports carry the same data; the byte enables pick the way
    assign ram_data0_w = ram_wdata;
    assign ram_data1_w = ram_wdata;

    // Per-way enable and byte-enable nibble decode from the latched way
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_way
            assign ram_en[gi]          = ram_access && (way_reg == 1'(gi));
            assign ram_wen[gi*4 +: 4]  = {4{ram_write && (way_reg == 1'(gi))}};
        end
    endgenerate

endmodule

// File: tb/tb_dcache_line_refill_ctrl.sv
// Directed bench for dcache_line_refill_ctrl: a cycle table covering clean
// and gapped refills with a protocol error, plus hand-written sequences for
// request back-pressure, dirty writeback and reset mid-refill.
module tb_dcache_line_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_way = 1'b0;
    logic [8:0]  req_index = '0;
    logic        req_wb = 1'b0;
    logic [31:0] req_wb_addr = '0;
    logic [31:0] req_rf_addr = '0;
    logic        busy, done, err;
    logic [11:0] ram_addr;
    logic [1:0]  ram_en;
    logic [7:0]  ram_wen;
    logic [31:0] ram_data0_w, ram_data1_w;
    logic [31:0] ram_data0_o = '0;
    logic [31:0] ram_data1_o = '0;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_gnt = 1'b0;
    logic        rd_valid = 1'b0;
    logic [31:0] rd_data = '0;
    logic        rd_last = 1'b0;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic        wr_gnt = 1'b0;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_last;
    logic        wr_ready = 1'b0;
    logic        wr_resp = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    dcache_line_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_way(req_way),
        .req_index(req_index), .req_wb(req_wb), .req_wb_addr(req_wb_addr),
        .req_rf_addr(req_rf_addr), .busy(busy), .done(done), .err(err),
        .ram_addr(ram_addr), .ram_en(ram_en), .ram_wen(ram_wen),
        .ram_data0_w(ram_data0_w), .ram_data1_w(ram_data1_w),
        .ram_data0_o(ram_data0_o), .ram_data1_o(ram_data1_o),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .wr_resp(wr_resp)
    );

    always #5 clk = ~clk;

    // RAM read model: way0 word w holds 0x11*w, way1 holds a distinct pattern
    always @(posedge clk) begin
        if (ram_en[0]) ram_data0_o <= 32'(ram_addr[2:0]) * 32'h11;
        if (ram_en[1]) ram_data1_o <= 32'hBAD0_0000 | 32'(ram_addr);
    end

    typedef struct {
        logic        req_valid;
        logic        req_way;
        logic [8:0]  req_index;
        logic [31:0] req_rf_addr;
        logic        rd_gnt;
        logic        rd_valid;
        logic [31:0] rd_data;
        logic        rd_last;
        logic        e_ready;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
        logic [1:0]  e_en;
        logic [7:0]  e_wen;
        logic [11:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_rd_req;
        logic [31:0] e_rd_addr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v_blank(input logic e_err);
        vec_t v;
        v.req_valid = 0; v.req_way = 0; v.req_index = '0; v.req_rf_addr = '0;
        v.rd_gnt = 0; v.rd_valid = 0; v.rd_data = '0; v.rd_last = 0;
        v.e_ready = 0; v.e_busy = 1; v.e_done = 0; v.e_err = e_err;
        v.e_en = '0; v.e_wen = '0; v.e_addr = '0; v.e_wdata = '0;
        v.e_rd_req = 0; v.e_rd_addr = '0;
        return v;
    endfunction

    function automatic vec_t v_req(input logic way, input logic [8:0] idx,
                                   input logic [31:0] a, input logic e_err);
        vec_t v = v_blank(e_err);
        v.req_valid = 1; v.req_way = way; v.req_index = idx; v.req_rf_addr = a;
        v.e_ready = 1; v.e_busy = 0;
        return v;
    endfunction

    function automatic vec_t v_rfreq(input logic gnt, input logic [31:0] a, input logic e_err);
        vec_t v = v_blank(e_err);
        v.rd_gnt = gnt; v.e_rd_req = 1; v.e_rd_addr = a;
        return v;
    endfunction

    function automatic vec_t v_beat(input logic way, input logic [11:0] addr,
                                    input logic [31:0] d, input logic last, input logic e_err);
        vec_t v = v_blank(e_err);
        v.rd_valid = 1; v.rd_data = d; v.rd_last = last;
        v.e_en = way ? 2'b10 : 2'b01;
        v.e_wen = way ? 8'hF0 : 8'h0F;
        v.e_addr = addr; v.e_wdata = d;
        return v;
    endfunction

    function automatic vec_t v_gap(input logic e_err);
        vec_t v = v_blank(e_err);
        v.rd_data = 32'hDEAD_BEEF;
        return v;
    endfunction

    function automatic vec_t v_done(input logic e_err);
        vec_t v = v_blank(e_err);
        v.e_done = 1;
        return v;
    endfunction

    function automatic vec_t v_idle(input logic e_err);
        vec_t v = v_blank(e_err);
        v.e_ready = 1; v.e_busy = 0;
        return v;
    endfunction

    // Eight back-to-back beats from RF_DAT, then the done pulse and return to IDLE
    task automatic beats(input logic way, input logic [8:0] idx, input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1;
            rd_data  = base + 32'(i);
            rd_last  = (i == 7);
            #1;
            chk("beat_en",    32'(ram_en),  way ? 32'h2 : 32'h1);
            chk("beat_wen",   32'(ram_wen), way ? 32'hF0 : 32'h0F);
            chk("beat_addr",  32'(ram_addr), 32'({idx, 3'(i)}));
            chk("beat_wdata", ram_data1_w, base + 32'(i));
            $display("beat %0d way %0d addr %h data %h", i, way, ram_addr, ram_data0_w);
            step();
        end
        rd_valid = 1'b0;
        rd_last  = 1'b0;
        #1;
        chk("fill_done", 32'(done), 32'h1);
        chk("fill_err",  32'(err),  32'h0);
        step();
        chk("fill_done_once", 32'(done), 32'h0);
        chk("fill_idle",      32'(busy), 32'h0);
    endtask

    initial begin
        vec_t v;
        bit   rf_phase;
        bit   resp_given;
        int   k;
        int   stall;
        int   rsp_wait;

        // ---- table: clean refill, gapped refill with rd_last error, err clear ----
        tbl.push_back(v_req(1'b1, 9'h05A, 32'h1000_0B40, 1'b0));
        tbl.push_back(v_rfreq(1'b1, 32'h1000_0B40, 1'b0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(v_beat(1'b1, 12'h2D0 + 12'(i), 32'hA0 + 32'(i), i == 7, 1'b0));
        tbl.push_back(v_done(1'b0));
        tbl.push_back(v_idle(1'b0));
        tbl.push_back(v_req(1'b0, 9'h1FF, 32'h2000_0040, 1'b0));
        tbl.push_back(v_rfreq(1'b0, 32'h2000_0040, 1'b0));
        tbl.push_back(v_rfreq(1'b1, 32'h2000_0040, 1'b0));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(v_beat(1'b0, 12'hFF8 + 12'(i), 32'h5500_0000 + 32'(i), i == 5, i > 5));
            if (i < 7) tbl.push_back(v_gap(i >= 5));
        end
        tbl.push_back(v_done(1'b1));
        tbl.push_back(v_idle(1'b1));
        tbl.push_back(v_req(1'b1, 9'h000, 32'h3000_0000, 1'b1));
        tbl.push_back(v_rfreq(1'b0, 32'h3000_0000, 1'b0));

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_outs",  {20'(ram_addr), ram_en, ram_wen, done, err},   32'h0);
        chk("rst_rd",    {31'(rd_addr), rd_req} | ram_data0_w,          32'h0);
        chk("rst_wr",    {wr_addr[28:0], wr_req, wr_valid, wr_last} | wr_data, 32'h0);
        rst = 1'b1;
        step();

        // ---- table-driven cycles ----
        for (int n = 0; n < tbl.size(); n++) begin
            v = tbl[n];
            req_valid   = v.req_valid;
            req_way     = v.req_way;
            req_index   = v.req_index;
            req_rf_addr = v.req_rf_addr;
            req_wb      = 1'b0;
            rd_gnt      = v.rd_gnt;
            rd_valid    = v.rd_valid;
            rd_data     = v.rd_data;
            rd_last     = v.rd_last;
            #1;
            chk("v_ready",   32'(req_ready),   32'(v.e_ready));
            chk("v_busy",    32'(busy),        32'(v.e_busy));
            chk("v_done",    32'(done),        32'(v.e_done));
            chk("v_err",     32'(err),         32'(v.e_err));
            chk("v_ram_en",  32'(ram_en),      32'(v.e_en));
            chk("v_ram_wen", 32'(ram_wen),     32'(v.e_wen));
            chk("v_ram_addr",32'(ram_addr),    32'(v.e_addr));
            chk("v_wdata0",  ram_data0_w,      v.e_wdata);
            chk("v_wdata1",  ram_data1_w,      v.e_wdata);
            chk("v_rd_req",  32'(rd_req),      32'(v.e_rd_req));
            chk("v_rd_addr", rd_addr,          v.e_rd_addr);
            chk("v_wr_idle", {30'd0, wr_req, wr_valid}, 32'h0);
            $display("vec %0d: en %b wen %h addr %h done %0d err %0d rd_req %0d",
                     n, ram_en, ram_wen, ram_addr, done, err, rd_req);
            step();
        end
        rd_gnt = 1'b0; rd_valid = 1'b0; rd_last = 1'b0;

        // ---- back-pressure: held req_valid ignored, rd_req held while no grant ----
        req_valid = 1'b1; req_wb = 1'b1; req_way = 1'b0; req_index = 9'h001;
        req_rf_addr = 32'hFFFF_0000;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_rd_req",  32'(rd_req),    32'h1);
            chk("bp_rd_addr", rd_addr,        32'h3000_0000);
            chk("bp_ready",   32'(req_ready), 32'h0);
            step();
        end
        rd_gnt = 1'b1; req_valid = 1'b0; req_wb = 1'b0;
        $display("back-pressure: grant after 10 cycles");
        step();
        rd_gnt = 1'b0;
        beats(1'b1, 9'h000, 32'h6600_0000);
        chk("bp_no_wb", 32'(wr_req), 32'h0);

        // ---- dirty writeback then refill ----
        req_valid = 1'b1; req_way = 1'b0; req_index = 9'h000; req_wb = 1'b1;
        req_wb_addr = 32'h4000_0100; req_rf_addr = 32'h5000_0200;
        #1;
        chk("wb_accept", 32'(req_ready), 32'h1);
        step();
        req_valid = 1'b0; req_wb = 1'b0;
        rf_phase = 0; resp_given = 0; k = 0; stall = 0; rsp_wait = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            wr_gnt = 1'b0; wr_ready = 1'b0; wr_resp = 1'b0;
            if (rd_req) begin
                rf_phase = 1;
                chk("wb_rd_req_after_resp", 32'(resp_given), 32'h1);
                break;
            end
            if (wr_req) begin
                chk("wb_addr", wr_addr, 32'h4000_0100);
                wr_gnt = 1'b1;
            end
            if (ram_en != 2'b00) begin
                chk("wb_ram_en",   32'(ram_en),   32'h1);
                chk("wb_ram_wen",  32'(ram_wen),  32'h0);
                chk("wb_ram_addr", 32'(ram_addr), 32'(k));
            end
            if (wr_valid) begin
                chk("wb_data", wr_data, 32'(k) * 32'h11);
                chk("wb_last", 32'(wr_last), 32'(k == 7));
                if (k == 3 && stall < 2) begin
                    stall++;
                    $display("wb beat %0d stalled, data %h", k, wr_data);
                end else begin
                    wr_ready = 1'b1;
                    $display("wb beat %0d data %h last %0d", k, wr_data, wr_last);
                    k++;
                end
            end else if (k == 8 && busy && !wr_req && ram_en == 2'b00) begin
                rsp_wait++;
                if (rsp_wait == 3) begin
                    wr_resp = 1'b1;
                    resp_given = 1;
                end
            end
            step();
        end
        wr_gnt = 1'b0; wr_ready = 1'b0; wr_resp = 1'b0;
        chk("wb_reached_refill", 32'(rf_phase), 32'h1);
        chk("wb_beats", 32'(k), 32'h8);
        chk("wb_stalls", 32'(stall), 32'h2);
        if (!rf_phase) begin
            $display("FAIL wb_timeout: refill never requested");
            $display("%0d/%0d checks passed", n_pass, n_total);
            $fatal(1, "writeback sequence did not complete");
        end
        chk("wb_rf_addr", rd_addr, 32'h5000_0200);
        rd_gnt = 1'b1;
        step();
        rd_gnt = 1'b0;
        beats(1'b0, 9'h000, 32'h7700_0000);

        // ---- reset mid-refill, then a clean refill ----
        req_valid = 1'b1; req_way = 1'b1; req_index = 9'h0AA; req_rf_addr = 32'h7000_0000;
        step();
        req_valid = 1'b0; rd_gnt = 1'b1;
        step();
        rd_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_valid = 1'b1; rd_data = 32'hCC00 + 32'(i);
            step();
        end
        rd_data = 32'hEEEE_EEEE;
        rst = 1'b0;
        #1;
        chk("mrst_ram_en",  32'(ram_en),    32'h0);
        chk("mrst_ram_wen", 32'(ram_wen),   32'h0);
        chk("mrst_ready",   32'(req_ready), 32'h1);
        chk("mrst_busy",    32'(busy),      32'h0);
        chk("mrst_rd_req",  32'(rd_req),    32'h0);
        chk("mrst_wdata",   ram_data0_w,    32'h0);
        $display("reset asserted after beat 3");
        rd_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        req_valid = 1'b1; req_way = 1'b1; req_index = 9'h0AA; req_rf_addr = 32'h7000_0040;
        #1;
        chk("post_rst_accept", 32'(req_ready), 32'h1);
        step();
        req_valid = 1'b0;
        chk("post_rst_rd_addr", rd_addr, 32'h7000_0040);
        rd_gnt = 1'b1;
        step();
        rd_gnt = 1'b0;
        beats(1'b1, 9'h0AA, 32'h1234_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "timeout");
    end

endmodule
